// File: rtl/wb_skid_stage_reg.sv
// wb_skid_stage_reg -- multi-lane execute->writeback register, 2-entry skid, ROB-age selective flush
// Rev 1.0
`default_nettype none

module wb_skid_stage_reg #(
  parameter int WORD_SIZE     = 32,
  parameter int INSTR_TYPE_SZ = 4,
  parameter int ROB_ID_W      = 7,
  parameter int LANES         = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LANES-1:0]                  in_valid,
  input  logic [LANES*INSTR_TYPE_SZ-1:0]    in_instruction_type,
  input  logic [LANES*WORD_SIZE-1:0]        in_pc,
  input  logic [LANES*WORD_SIZE-1:0]        in_result,
  input  logic [LANES*ROB_ID_W-1:0]         in_rob_id,
  output logic                              in_ready,
  output logic [LANES-1:0]                  out_valid,
  output logic [LANES*INSTR_TYPE_SZ-1:0]    out_instruction_type,
  output logic [LANES*WORD_SIZE-1:0]        out_pc,
  output logic [LANES*WORD_SIZE-1:0]        out_result,
  output logic [LANES*ROB_ID_W-1:0]         out_rob_id,
  input  logic                              out_ready,
  input  logic                              flush,
  input  logic [ROB_ID_W-1:0]               flush_rob_id,
  input  logic [ROB_ID_W-1:0]               rob_head
);

  localparam int TW = LANES * INSTR_TYPE_SZ;
  localparam int PW = LANES * WORD_SIZE;
  localparam int RW = LANES * ROB_ID_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;

  logic [LANES-1:0] main_valid_q, main_valid_d;
  logic [TW-1:0]    main_type_q, main_type_d;
  logic [PW-1:0]    main_pc_q, main_pc_d;
  logic [PW-1:0]    main_result_q, main_result_d;
  logic [RW-1:0]    main_rob_q, main_rob_d;

  logic [LANES-1:0] skid_valid_q, skid_valid_d;
  logic [TW-1:0]    skid_type_q, skid_type_d;
  logic [PW-1:0]    skid_pc_q, skid_pc_d;
  logic [PW-1:0]    skid_result_q, skid_result_d;
  logic [RW-1:0]    skid_rob_q, skid_rob_d;

  logic             in_fire, out_fire;
  logic [LANES-1:0] kill_main, kill_skid, kill_in;
  logic [LANES-1:0] main_live, skid_live, in_live;

  // Ages are taken relative to rob_head; ROB_ID_W-bit truncation gives the modulo wrap.
  function automatic logic [LANES-1:0] kill_lanes(
    input logic [RW-1:0]       ids,
    input logic                fl,
    input logic [ROB_ID_W-1:0] fid,
    input logic [ROB_ID_W-1:0] head
  );
    logic [ROB_ID_W-1:0] age_f;
    logic [ROB_ID_W-1:0] age_l;
    kill_lanes = '0;
    age_f      = fid - head;
    for (int i = 0; i < LANES; i++) begin
      age_l         = ids[i*ROB_ID_W +: ROB_ID_W] - head;
      kill_lanes[i] = fl && (age_l > age_f);
    end
  endfunction

  always_comb begin
    in_fire   = in_ready_q & (|in_valid);
    out_fire  = (|main_valid_q) & out_ready;
    kill_main = kill_lanes(main_rob_q, flush, flush_rob_id, rob_head);
    kill_skid = kill_lanes(skid_rob_q, flush, flush_rob_id, rob_head);
    kill_in   = kill_lanes(in_rob_id,  flush, flush_rob_id, rob_head);

    // A presented bundle taken by writeback is gone even if flushed this cycle.
    main_live = out_fire ? '0 : (main_valid_q & ~kill_main);
    skid_live = skid_valid_q & ~kill_skid;
    in_live   = in_fire ? (in_valid & ~kill_in) : '0;

    main_valid_d  = main_valid_q;
    main_type_d   = main_type_q;
    main_pc_d     = main_pc_q;
    main_result_d = main_result_q;
    main_rob_d    = main_rob_q;
    skid_valid_d  = skid_valid_q;
    skid_type_d   = skid_type_q;
    skid_pc_d     = skid_pc_q;
    skid_result_d = skid_result_q;
    skid_rob_d    = skid_rob_q;

    // Surviving entries compact towards MAIN in arrival order: MAIN, SKID, incoming.
    if (|main_live) begin
      main_valid_d = main_live;
      if (|skid_live) begin
        skid_valid_d = skid_live;
      end else if (|in_live) begin
        skid_valid_d  = in_live;
        skid_type_d   = in_instruction_type;
        skid_pc_d     = in_pc;
        skid_result_d = in_result;
        skid_rob_d    = in_rob_id;
      end else begin
        skid_valid_d = '0;
      end
    end else if (|skid_live) begin
      main_valid_d  = skid_live;
      main_type_d   = skid_type_q;
      main_pc_d     = skid_pc_q;
      main_result_d = skid_result_q;
      main_rob_d    = skid_rob_q;
      if (|in_live) begin
        skid_valid_d  = in_live;
        skid_type_d   = in_instruction_type;
        skid_pc_d     = in_pc;
        skid_result_d = in_result;
        skid_rob_d    = in_rob_id;
      end else begin
        skid_valid_d = '0;
      end
    end else if (|in_live) begin
      main_valid_d  = in_live;
      main_type_d   = in_instruction_type;
      main_pc_d     = in_pc;
      main_result_d = in_result;
      main_rob_d    = in_rob_id;
      skid_valid_d  = '0;
    end else begin
      main_valid_d = '0;
      skid_valid_d = '0;
    end

    if (|skid_valid_d) begin
      state_d = ST_FULL;
    end else if (|main_valid_d) begin
      state_d = ST_ONE;
    end else begin
      state_d = ST_EMPTY;
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_EMPTY;
      in_ready_q    <= 1'b1;
      main_valid_q  <= '0;
      main_type_q   <= '0;
      main_pc_q     <= '0;
      main_result_q <= '0;
      main_rob_q    <= '0;
      skid_valid_q  <= '0;
      skid_type_q   <= '0;
      skid_pc_q     <= '0;
      skid_result_q <= '0;
      skid_rob_q    <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      main_valid_q  <= main_valid_d;
      main_type_q   <= main_type_d;
      main_pc_q     <= main_pc_d;
      main_result_q <= main_result_d;
      main_rob_q    <= main_rob_d;
      skid_valid_q  <= skid_valid_d;
      skid_type_q   <= skid_type_d;
      skid_pc_q     <= skid_pc_d;
      skid_result_q <= skid_result_d;
      skid_rob_q    <= skid_rob_d;
    end
  end

  assign in_ready             = in_ready_q;
  assign out_valid            = main_valid_q;
  assign out_instruction_type = main_type_q;
  assign out_pc               = main_pc_q;
  assign out_result           = main_result_q;
  assign out_rob_id           = main_rob_q;

endmodule

`default_nettype wire

// File: doc/wb_skid_stage_reg.md
Name: wb_skid_stage_reg

Overview:
- Parametrised, multi-lane pipeline register between the last execute/memory stage and writeback.
- Carries per-lane {instruction_type, pc, result, rob_id, valid} as a bundle, with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under backpressure.
- Supports selective flush by ROB age, so younger-than-mispredict lanes are killed in place.

Parameters:
- WORD_SIZE, 32 (`WORD_SIZE): pc/result width.
- INSTR_TYPE_SZ, `INSTR_TYPE_SZ: instruction type width.
- ROB_ID_W, 7: ROB id width; ids wrap modulo 2^ROB_ID_W.
- LANES, 2: instructions per bundle.

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  LANES  per-lane valid of incoming bundle.
- in_instruction_type  in  LANES*INSTR_TYPE_SZ  lane i at [i*INSTR_TYPE_SZ +: INSTR_TYPE_SZ].
- in_pc  in  LANES*WORD_SIZE  per-lane pc.
- in_result  in  LANES*WORD_SIZE  per-lane result.
- in_rob_id  in  LANES*ROB_ID_W  per-lane ROB id.
- in_ready  out  1  stage can accept a bundle this cycle.
- out_valid  out  LANES  per-lane valid of presented bundle.
- out_instruction_type, out_pc, out_result, out_rob_id  out  same widths as inputs  presented payload.
- out_ready  in  1  writeback accepts the presented bundle.
- flush  in  1  kill lanes younger than flush_rob_id.
- flush_rob_id  in  ROB_ID_W  id of the flushing instruction (survives).
- rob_head  in  ROB_ID_W  oldest live ROB id, used as age reference.

Behaviour:
- Storage: MAIN entry drives all outputs directly from registers (no combinational path input->output). SKID entry holds the overflow bundle.
- Reset (reset==0, async): both entries invalid, every lane valid 0, all payload regs 0, in_ready=1, out_valid=0.
- State machine on entry occupancy:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: MAIN holds a bundle, in_ready=1.
  - FULL: MAIN+SKID hold bundles, in_ready=0.
- in_ready is a registered function of state: 1 in EMPTY/ONE, 0 in FULL.
- in_fire = in_ready & |in_valid. A bundle with in_valid==0 is never stored.
- out_fire = |out_valid & out_ready.
- Transitions, no flush:
  - EMPTY + in_fire -> ONE (load MAIN).
  - ONE + in_fire & !out_fire -> FULL (load SKID).
  - ONE + in_fire & out_fire -> ONE (load MAIN).
  - ONE + !in_fire & out_fire -> EMPTY.
  - FULL + out_fire -> ONE (SKID moves to MAIN; in_ready was 0, so there is no input).
  - Otherwise hold.
- Latency: a bundle accepted at edge N is presented from edge N+1. Sustained throughput is 1 bundle/cycle with out_ready=1.
- Bundles leave in arrival order; lane positions never change within a bundle.
- Age rule: age(x) = (x - rob_head) mod 2^ROB_ID_W, unsigned ROB_ID_W-bit. A lane is killed when flush=1 and age(lane_rob_id) > age(flush_rob_id). Equal age survives.
- Flush is applied at the clock edge, to MAIN, SKID and the incoming bundle (if in_fire), before the state update.
  - A killed lane's valid bit clears; its payload holds its previous value.
  - An entry left with no valid lanes becomes empty. If MAIN empties while SKID is non-empty, SKID moves to MAIN on the same edge.
  - An incoming bundle fully killed is not stored.
- Simultaneous out_fire and flush: the bundle presented that cycle counts as consumed; the flush does not retract it. Writeback filters same-cycle kills itself.
- Invalid lanes of a stored bundle never assert out_valid; their payload is don't-care.
- Wrap-around: age arithmetic must be correct when ids straddle 2^ROB_ID_W-1 -> 0.
- Reset mid-operation: asynchronously empties both entries regardless of handshake; in_ready=1 at the first edge after release.

Test Plan:
- Streaming: LANES=2, out_ready=1; bundles pc=0x100/0x104, 0x108/0x10C on consecutive cycles -> each appears 1 cycle later, in_ready stays 1, no drops.
- Backpressure: out_ready=0 for 3 cycles while 3 bundles offered -> first in MAIN, second in SKID, in_ready=0 from cycle 2, third held by source. out_ready=1 then drains in order with no bubble.
- Partial flush: rob_head=5, MAIN lanes rob_id 7/8, flush_rob_id=7 -> lane1 (id 8) out_valid drops to 0, lane0 (id 7) stays 1.
- Wrap flush: rob_head=126, lanes rob_id 127/0 in MAIN, SKID rob_id 1/2, flush_rob_id=127 -> MAIN keeps lane0 only, SKID empties, state ONE, in_ready=1.
- Full kill with promotion: FULL state, MAIN ids 10/11, SKID ids 9/9, rob_head=8, flush_rob_id=9 -> MAIN empties, SKID promoted to MAIN, out_valid=2'b11 with ids 9/9 next cycle.
- Async reset: assert reset=0 between edges while FULL -> out_valid=0 and payloads 0 immediately, in_ready=1 after release, next bundle latency 1.
